// File: rtl/pmi_fifo_pkg.sv
// pmi_fifo_pkg: shared helpers, regmode names and parameter checks
// for the pmi_fifo_sc single-clock FIFO (optional: PMI_FIFO_ERR_FLAGS_EN).
`ifndef PMI_FIFO_PKG_SV
`define PMI_FIFO_PKG_SV

`define PMI_FIFO_CHECK(lbl, cond) \
  if (!(cond)) begin : lbl \
    $error("pmi_fifo_sc: illegal parameter combination"); \
  end

package pmi_fifo_pkg;

  localparam string PMI_REG   = "reg";
  localparam string PMI_NOREG = "noreg";

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

`endif

// File: rtl/pmi_fifo_mem.sv
// pmi_fifo_mem: simple dual-port inferred RAM, registered read,
// optional second output register for read latency 2.
module pmi_fifo_mem
  import pmi_fifo_pkg::*;
#(
  parameter int    DW      = 8,
  parameter int    DEPTH   = 16,
  parameter int    AW      = 4,
  parameter string REGMODE = PMI_NOREG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_d, rd_q;

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rd_d = rd_q;
    if (re) rd_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  if (REGMODE == PMI_REG) begin : g_reg
    logic          vld_d, vld_q;
    logic [DW-1:0] out_d, out_q;

    always_comb begin
      vld_d = re;
      out_d = out_q;
      if (vld_q) out_d = rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        out_q <= '0;
      end else begin
        vld_q <= vld_d;
        out_q <= out_d;
      end
    end

    assign q = out_q;
  end else begin : g_noreg
    assign q = rd_q;
  end

endmodule

// File: rtl/pmi_fifo_sc.sv
// pmi_fifo_sc: single-clock FIFO with count and registered flags.
// Define PMI_FIFO_ERR_FLAGS_EN for sticky Overflow/Underflow + ClrErr.
module pmi_fifo_sc
  import pmi_fifo_pkg::*;
#(
  parameter int    pmi_data_width        = 8,
  parameter int    pmi_data_depth        = 16,
  parameter int    pmi_addr_width        = 4,
  parameter int    pmi_almost_full_flag  = 12,
  parameter int    pmi_almost_empty_flag = 2,
  parameter string pmi_regmode           = PMI_NOREG
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [pmi_data_width-1:0] Data,
  input  logic                      WrEn,
  input  logic                      RdEn,
  output logic [pmi_data_width-1:0] Q,
  output logic [pmi_addr_width:0]   Count,
  output logic                      Empty,
  output logic                      Full,
  output logic                      AlmostEmpty,
  output logic                      AlmostFull
`ifdef PMI_FIFO_ERR_FLAGS_EN
  ,
  input  logic                      ClrErr,
  output logic                      Overflow,
  output logic                      Underflow
`endif
);

  localparam int AW = pmi_addr_width;

  `PMI_FIFO_CHECK(g_chk_dw,
    (pmi_data_width >= 1) && (pmi_data_width <= 72))
  `PMI_FIFO_CHECK(g_chk_depth,
    (pmi_data_depth >= 2) && (clog2(pmi_data_depth) <= AW))
  `PMI_FIFO_CHECK(g_chk_af,
    (pmi_almost_full_flag >= 1) &&
    (pmi_almost_full_flag <= pmi_data_depth))
  `PMI_FIFO_CHECK(g_chk_ae,
    (pmi_almost_empty_flag >= 0) &&
    (pmi_almost_empty_flag < pmi_data_depth))
  `PMI_FIFO_CHECK(g_chk_mode,
    (pmi_regmode == PMI_REG) || (pmi_regmode == PMI_NOREG))

  localparam logic [AW-1:0] LAST  = AW'(pmi_data_depth - 1);
  localparam logic [AW:0]   DEPTH = (AW+1)'(pmi_data_depth);
  localparam logic [AW:0]   AF_TH = (AW+1)'(pmi_almost_full_flag);
  localparam logic [AW:0]   AE_TH = (AW+1)'(pmi_almost_empty_flag);

  logic          wr_ok, rd_ok;
  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [AW-1:0] rd_ptr_d, rd_ptr_q;
  logic [AW:0]   count_d, count_q;
  logic          empty_d, empty_q;
  logic          full_d, full_q;
  logic          ae_d, ae_q;
  logic          af_d, af_q;

  always_comb begin
    wr_ok    = WrEn & ~full_q;
    rd_ok    = RdEn & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Flags follow the next count so they move on the same edge.
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH);
    ae_d    = (count_d <= AE_TH);
    af_d    = (count_d >= AF_TH);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
    end
  end

  pmi_fifo_mem #(
    .DW      (pmi_data_width),
    .DEPTH   (pmi_data_depth),
    .AW      (AW),
    .REGMODE (pmi_regmode)
  ) u_mem (
    .clk   (Clock),
    .rst_n (Reset_n),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (Data),
    .re    (rd_ok),
    .raddr (rd_ptr_q),
    .q     (Q)
  );

  assign Count       = count_q;
  assign Empty       = empty_q;
  assign Full        = full_q;
  assign AlmostEmpty = ae_q;
  assign AlmostFull  = af_q;

`ifdef PMI_FIFO_ERR_FLAGS_EN
  logic ovf_d, ovf_q;
  logic udf_d, udf_q;

  // A new error in the clear cycle keeps the flag set.
  always_comb begin
    ovf_d = (ovf_q & ~ClrErr) | (WrEn & full_q);
    udf_d = (udf_q & ~ClrErr) | (RdEn & empty_q);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign Overflow  = ovf_q;
  assign Underflow = udf_q;
`endif

endmodule

// File: tb/tb_pmi_fifo_sc.sv
// tb_pmi_fifo_sc: directed checks of pmi_fifo_sc in depth-16 noreg,
// depth-12 and "reg" output configurations.
module tb_pmi_fifo_sc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] din_a = '0, din_b = '0, din_c = '0;
  logic wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0, wr_c = 0, rd_c = 0;
  logic [7:0] q_a, q_b, q_c;
  logic [4:0] cnt_a, cnt_b, cnt_c;
  logic em_a, fu_a, ae_a, af_a;
  logic em_b, fu_b, ae_b, af_b;
  logic em_c, fu_c, ae_c, af_c;

  pmi_fifo_sc u_a (
    .Clock(clk), .Reset_n(rst_n), .Data(din_a), .WrEn(wr_a),
    .RdEn(rd_a), .Q(q_a), .Count(cnt_a), .Empty(em_a), .Full(fu_a),
    .AlmostEmpty(ae_a), .AlmostFull(af_a)
  );

  pmi_fifo_sc #(.pmi_data_depth(12), .pmi_almost_full_flag(10)) u_b (
    .Clock(clk), .Reset_n(rst_n), .Data(din_b), .WrEn(wr_b),
    .RdEn(rd_b), .Q(q_b), .Count(cnt_b), .Empty(em_b), .Full(fu_b),
    .AlmostEmpty(ae_b), .AlmostFull(af_b)
  );

  pmi_fifo_sc #(.pmi_regmode("reg")) u_c (
    .Clock(clk), .Reset_n(rst_n), .Data(din_c), .WrEn(wr_c),
    .RdEn(rd_c), .Q(q_c), .Count(cnt_c), .Empty(em_c), .Full(fu_c),
    .AlmostEmpty(ae_c), .AlmostFull(af_c)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] mq[$];
  logic [7:0] qexp;
  int cnt;
  bit wok, rok;

  initial begin
    #12;
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_q_a", q_a, 0);
    chk("rst_em_a", em_a, 1);
    chk("rst_fu_a", fu_a, 0);
    chk("rst_ae_a", ae_a, 1);
    chk("rst_af_a", af_a, 0);
    chk("rst_b", {em_b, fu_b, ae_b, af_b}, 4'b1010);
    chk("rst_c", {em_c, fu_c, ae_c, af_c}, 4'b1010);
    chk("rst_cnt_bc", {cnt_b, cnt_c}, 0);
    step();
    rst_n = 1'b1;
    step();

    // fill depth-16
    for (int i = 0; i < 16; i++) begin
      wr_a = 1; din_a = 8'(i);
      step();
      chk("fill_cnt", cnt_a, i + 1);
      chk("fill_af", af_a, (i + 1 >= 12));
      chk("fill_fu", fu_a, (i + 1 == 16));
    end
    din_a = 8'hFF;
    step();
    chk("ovf_cnt", cnt_a, 16);
    wr_a = 0;

    // drain
    for (int k = 0; k < 16; k++) begin
      rd_a = 1;
      step();
      chk("drain_q", q_a, k);
      chk("drain_cnt", cnt_a, 15 - k);
      chk("drain_ae", ae_a, (15 - k <= 2));
      chk("drain_em", em_a, (k == 15));
    end
    step();
    chk("udf_q", q_a, 8'h0F);
    chk("udf_cnt", cnt_a, 0);
    rd_a = 0;

    // hold count 5 across wrap
    for (int i = 0; i < 5; i++) begin
      wr_a = 1; din_a = 8'h20 + 8'(i);
      step();
    end
    chk("pre5_cnt", cnt_a, 5);
    for (int i = 0; i < 20; i++) begin
      wr_a = 1; rd_a = 1; din_a = 8'h25 + 8'(i);
      step();
      chk("sim_q", q_a, 8'h20 + 8'(i));
      chk("sim_cnt", cnt_a, 5);
    end
    wr_a = 0;
    for (int k = 0; k < 5; k++) begin
      rd_a = 1;
      step();
      chk("tail_q", q_a, 8'h34 + 8'(k));
    end
    rd_a = 0;
    chk("tail_em", em_a, 1);

    // reg mode latency
    wr_c = 1; din_c = 8'hA5;
    step();
    wr_c = 0; rd_c = 1;
    step();
    rd_c = 0;
    chk("reg_q_e1", q_c, 0);
    step();
    chk("reg_q_e2", q_c, 8'hA5);
    step();
    chk("reg_q_hold", q_c, 8'hA5);
    chk("reg_em", em_c, 1);

    // depth-12 against a queue model
    cnt = 0; qexp = 8'h00;
    for (int i = 0; i < 14; i++) begin
      wr_b = 1; rd_b = 0; din_b = 8'h40 + 8'(i);
      if (cnt < 12) begin mq.push_back(din_b); cnt++; end
      step();
      chk("d12_fill_cnt", cnt_b, cnt);
      chk("d12_full", fu_b, (cnt == 12));
    end
    chk("d12_af", af_b, 1);
    for (int i = 0; i < 30; i++) begin
      wr_b = (i % 4 != 3); rd_b = (i % 3 != 2);
      din_b = 8'h80 + 8'(i);
      wok = wr_b && (cnt < 12);
      rok = rd_b && (cnt > 0);
      if (rok) qexp = mq.pop_front();
      if (wok) mq.push_back(din_b);
      cnt = cnt + int'(wok) - int'(rok);
      step();
      chk("d12_mix_q", q_b, qexp);
      chk("d12_mix_cnt", cnt_b, cnt);
    end
    wr_b = 0;
    for (int k = 0; k < 12; k++) begin
      rd_b = 1;
      if (cnt > 0) begin qexp = mq.pop_front(); cnt--; end
      step();
      chk("d12_drain_q", q_b, qexp);
      chk("d12_drain_cnt", cnt_b, cnt);
    end
    rd_b = 0;
    chk("d12_em", em_b, 1);

    // asynchronous reset mid-burst
    for (int i = 0; i < 7; i++) begin
      wr_a = 1; din_a = 8'h50 + 8'(i);
      step();
    end
    chk("mid_cnt7", cnt_a, 7);
    chk("mid_q_pre", q_a, 8'h38);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", cnt_a, 0);
    chk("arst_em", em_a, 1);
    chk("arst_q", q_a, 0);
    wr_a = 0;
    step();
    rst_n = 1'b1;
    step();
    wr_a = 1; din_a = 8'h3C;
    step();
    wr_a = 0; rd_a = 1;
    step();
    rd_a = 0;
    chk("post_q", q_a, 8'h3C);
    chk("post_cnt", cnt_a, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
